// File: rtl/zigbee_io_pkg.sv
// Shared types and default bus widths for the zigbee pad-mux slice.
// IN_W/OUT_W defaults are the same values zigbee_platform uses for its pad ring.
package zigbee_io_pkg;

    localparam int IN_W_DEF  = 22;
    localparam int OUT_W_DEF = 18;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zigbee_sync_bus.sv
// Plain flop-chain synchroniser for asynchronous pad inputs.
// Bits are synchronised independently; there is no bus coherency.
module zigbee_sync_bus #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
            r_chain[0] <= d_i;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/zigbee_io_mux.sv
// Pad-mux stage: synchronises pad inputs and mode select, qualifies mode
// changes and drives registered pad outputs, blanking them while switching.
module zigbee_io_mux
    import zigbee_io_pkg::*;
#(
    parameter int IN_W         = IN_W_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int SYNC_STAGES  = 2,
    parameter int SEL_STABLE   = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       sel_i,
    input  logic [IN_W-1:0]  mux_i,
    output logic [OUT_W-1:0] mux_o,
    input  logic [OUT_W-1:0] src0_i,
    input  logic [OUT_W-1:0] src1_i,
    input  logic [OUT_W-1:0] src2_i,
    input  logic [OUT_W-1:0] src3_i,
    output logic [IN_W-1:0]  in_o,
    output logic [1:0]       mode_o,
    output logic             switching_o
);

    localparam int CNT_W = $clog2(max2(SEL_STABLE, BLANK_CYCLES) + 1);

    logic [1:0]       w_sel_raw;
    mode_t            w_sel_s;
    logic [OUT_W-1:0] w_src;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    mode_t            r_mode;
    mode_t            r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_mux;
    logic             r_switching;

    zigbee_sync_bus #(.W(IN_W), .STAGES(SYNC_STAGES)) u_sync_in (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (mux_i),
        .q_o     (in_o)
    );

    zigbee_sync_bus #(.W(2), .STAGES(SYNC_STAGES)) u_sync_sel (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (sel_i),
        .q_o     (w_sel_raw)
    );

    assign w_sel_s   = mode_t'(w_sel_raw);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_src = '0;
        case (r_mode)
            MODE0: w_src = src0_i;
            MODE1: w_src = src1_i;
            MODE2: w_src = src2_i;
            MODE3: w_src = src3_i;
            default: w_src = '0;
        endcase
    end

    // mux_o is already zeroed on the edge that enters BLANK, so the pads show
    // zero for every cycle switching_o reports BLANK.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_ACTIVE;
            r_mode      <= MODE0;
            r_cand      <= MODE0;
            r_cnt       <= '0;
            r_mux       <= '0;
            r_switching <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    r_mux <= w_src;
                    if (w_sel_s != r_mode) begin
                        r_cand      <= w_sel_s;
                        r_cnt       <= CNT_W'(1);
                        r_state     <= ST_QUALIFY;
                        r_switching <= 1'b1;
                    end
                end
                ST_QUALIFY: begin
                    if (w_sel_s == r_mode) begin
                        r_mux       <= w_src;
                        r_cnt       <= '0;
                        r_state     <= ST_ACTIVE;
                        r_switching <= 1'b0;
                    end else if (w_sel_s != r_cand) begin
                        r_mux  <= w_src;
                        r_cand <= w_sel_s;
                        r_cnt  <= CNT_W'(1);
                    end else if (w_cnt_inc >= CNT_W'(SEL_STABLE)) begin
                        r_mux   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                    end else begin
                        r_mux <= w_src;
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_BLANK: begin
                    r_mux <= '0;
                    if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        r_mode      <= r_cand;
                        r_cnt       <= '0;
                        r_state     <= ST_ACTIVE;
                        r_switching <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_mux       <= '0;
                    r_cnt       <= '0;
                    r_state     <= ST_ACTIVE;
                    r_switching <= 1'b0;
                end
            endcase
        end
    end

    assign mux_o       = r_mux;
    assign mode_o      = r_mode;
    assign switching_o = r_switching;

endmodule

// File: tb/tb_zigbee_io_mux.sv
// Scoreboard bench for zigbee_io_mux: a run-length reference model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_zigbee_io_mux;

    localparam int IN_W         = 22;
    localparam int OUT_W        = 18;
    localparam int SYNC_STAGES  = 2;
    localparam int SEL_STABLE   = 4;
    localparam int BLANK_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       sel_i = 2'd0;
    logic [IN_W-1:0]  mux_i = '0;
    logic [OUT_W-1:0] src [4];
    logic [OUT_W-1:0] mux_o;
    logic [IN_W-1:0]  in_o;
    logic [1:0]       mode_o;
    logic             switching_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    always #5 clk = ~clk;

    zigbee_io_mux #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SYNC_STAGES(SYNC_STAGES),
        .SEL_STABLE(SEL_STABLE), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .sel_i       (sel_i),
        .mux_i       (mux_i),
        .mux_o       (mux_o),
        .src0_i      (src[0]),
        .src1_i      (src[1]),
        .src2_i      (src[2]),
        .src3_i      (src[3]),
        .in_o        (in_o),
        .mode_o      (mode_o),
        .switching_o (switching_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OUT_W-1:0] mux;
        logic [IN_W-1:0]  inp;
        logic [1:0]       mode;
        logic             sw;
    } exp_t;

    exp_t            exp_q [$];
    logic [1:0]      q_sel [$];
    logic [IN_W-1:0] q_in  [$];
    logic [1:0]      m_mode = 2'd0;
    logic [1:0]      m_cand = 2'd0;
    logic            m_sw   = 1'b0;
    int              m_run  = 0;   // consecutive synced cycles the candidate has held
    int              m_blank_left = 0;

    always @(posedge clk) begin
        exp_t e;
        logic [1:0] sel_s;
        logic [OUT_W-1:0] nxt_mux;
        nxt_mux = '0;
        if (rst) begin
            q_sel = {};
            q_in  = {};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                q_sel.push_back(2'd0);
                q_in.push_back('0);
            end
            m_mode = 2'd0; m_cand = 2'd0; m_sw = 1'b0; m_run = 0; m_blank_left = 0;
        end else begin
            sel_s = q_sel[0];
            void'(q_sel.pop_front()); q_sel.push_back(sel_i);
            void'(q_in.pop_front());  q_in.push_back(mux_i);
            if (m_blank_left > 0) begin
                m_blank_left--;
                if (m_blank_left == 0) begin
                    m_mode = m_cand;
                    m_sw   = 1'b0;
                end
            end else begin
                nxt_mux = src[m_mode];
                if (sel_s == m_mode) begin
                    m_run = 0;
                    m_sw  = 1'b0;
                end else begin
                    if (m_run > 0 && sel_s == m_cand) m_run++;
                    else begin
                        m_cand = sel_s;
                        m_run  = 1;
                    end
                    m_sw = 1'b1;
                    // at least one QUALIFY cycle always follows detection
                    if (m_run >= 2 && m_run >= SEL_STABLE) begin
                        m_blank_left = BLANK_CYCLES;
                        m_run   = 0;
                        nxt_mux = '0;
                    end
                end
            end
        end
        e.mux  = nxt_mux;
        e.inp  = rst ? '0 : q_in[0];
        e.mode = m_mode;
        e.sw   = m_sw;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_pops++;
            chk("mux_o",       32'(mux_o),       32'(e.mux));
            chk("in_o",        32'(in_o),        32'(e.inp));
            chk("mode_o",      32'(mode_o),      32'(e.mode));
            chk("switching_o", 32'(switching_o), 32'(e.sw));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mode(input logic [1:0] m, input string name);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mode_o == m && !switching_o) break;
        end
        chk(name, {29'd0, switching_o, mode_o}, {29'd0, 1'b0, m});
    endtask

    initial begin
        int k_in, k_sw, sw_cnt, zero_cnt, bad_mode;
        bit mode1_seen, got_blank;
        for (int i = 0; i < 4; i++) src[i] = 18'h3FFFF;

        // reset, all sources all-ones, sel held at 0
        cyc(3);
        chk("mux_in_reset", 32'(mux_o), 32'd0);
        rst = 1'b0;
        cyc(1);
        chk("mux_after_release", 32'(mux_o), 32'h3FFFF);
        chk("mode_after_release", 32'(mode_o), 32'd0);
        cyc(3);

        // pad input latency and a concurrent switch to mode 2
        mux_i = 22'h2AAAAA; src[2] = 18'h12345; sel_i = 2'd2;
        k_in = -1; k_sw = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k_in < 0 && in_o == 22'h2AAAAA) k_in = k;
            if (k_sw < 0 && switching_o) k_sw = k;
        end
        chk("in_o_latency", 32'(k_in), 32'(SYNC_STAGES));
        chk("switch_rise_latency", 32'(k_sw), 32'(SYNC_STAGES + 1));
        wait_mode(2'd2, "mode2_applied");
        chk("mux_mode2", 32'(mux_o), 32'h12345);

        // back to mode 0 with distinct nonzero sources
        for (int i = 0; i < 4; i++) src[i] = OUT_W'($urandom) | OUT_W'(1);
        sel_i = 2'd0;
        wait_mode(2'd0, "mode0_restored");
        cyc(2);

        // 3-cycle glitch on sel must be rejected without blanking
        sel_i = 2'd1;
        sw_cnt = 0; zero_cnt = 0; bad_mode = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) sel_i = 2'd0;
            if (switching_o) sw_cnt++;
            if (mux_o == '0) zero_cnt++;
            if (mode_o != 2'd0) bad_mode++;
        end
        chk("glitch_switch_cycles", 32'(sw_cnt), 32'd3);
        chk("glitch_no_blank", 32'(zero_cnt), 32'd0);
        chk("glitch_mode_kept", 32'(bad_mode), 32'd0);

        // candidate restart: 1 for two cycles, then 3 held
        sel_i = 2'd1;
        cyc(2);
        sel_i = 2'd3;
        mode1_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mode_o == 2'd1) mode1_seen = 1'b1;
            if (mode_o == 2'd3 && !switching_o) break;
        end
        chk("restart_mode3", 32'(mode_o), 32'd3);
        chk("restart_mode1_never", 32'(mode1_seen), 32'd0);

        // reset asserted mid-BLANK toward mode 3
        sel_i = 2'd0;
        wait_mode(2'd0, "mode0_before_rst");
        sel_i = 2'd3;
        got_blank = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_blank_left > 0) begin got_blank = 1'b1; break; end
        end
        chk("reached_blank", 32'(got_blank), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_mux", 32'(mux_o), 32'd0);
        chk("async_rst_mode", 32'(mode_o), 32'd0);
        chk("async_rst_sw", 32'(switching_o), 32'd0);
        cyc(2);
        rst = 1'b0;
        got_blank = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (switching_o && mux_o == '0) got_blank = 1'b1;
            if (mode_o == 2'd3 && !switching_o) break;
        end
        chk("rerun_blanked", 32'(got_blank), 32'd1);
        chk("rerun_mode3", 32'(mode_o), 32'd3);

        // randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            sel_i = 2'($urandom_range(0, 3));
            for (int h = $urandom_range(1, 8); h > 0; h--) begin
                mux_i = IN_W'($urandom);
                if ($urandom_range(0, 3) == 0) src[$urandom_range(0, 3)] = OUT_W'($urandom);
                rst = ($urandom_range(0, 299) == 0);
                @(negedge clk);
            end
        end
        rst = 1'b0;
        cyc(4);

        chk("monitor_activity", 32'(n_pops > 1000), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
